calc_datapath: RTL and testbench

Datapath of the small calculator, directly downstream of the calculator control unit. It consumes the unit's per-state control word (s1, WA, WE, RAA/REA, RAB/REB, C, s2) and holds a 4-entry register file, the ALU, the write-data mux (MUX1) and the output mux (MUX2). It also has a registered result/flag stage that drives the LED/7-seg output logic.

---
 rtl/calc_datapath.sv | 173 +++++++++++++++++
 tb/tb_calc_datapath.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/calc_datapath.sv
// calc_datapath -- datapath of the small calculator.
//
// Holds a 4-entry register file (R0-R3), the ALU, the register-file
// write-data mux (MUX1) and the output mux (MUX2), plus a registered
// result/flag stage that feeds the LED/7-seg logic.
//
// Optional feature macro: CALC_SIGNED_OVF_EN
//   defined   -> ovf captures the ALU signed-overflow flag alongside carry
//   undefined -> ovf is tied to 0 and no overflow logic exists
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   in1, in2     W-bit operands from the switches
//   s1           MUX1 select: 0 ALU, 1 zero, 2 in2, 3 in1
//   WA, WE       register-file write address / enable
//   RAA, REA     read port A address / enable (disabled port reads 0)
//   RAB, REB     read port B address / enable
//   C            ALU op: 0 ADD, 1 SUB, 2 AND, 3 XOR
//   s2           MUX2 select: 1 loads ALU result into out
//   out          registered displayed result
//   carry        registered carry (ADD) / borrow (SUB)
//   ovf          registered signed overflow (0 when feature disabled)
//   result_valid one-cycle pulse when out is loaded
module calc_datapath #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [1:0]   s1,
  input  logic [1:0]   WA,
  input  logic         WE,
  input  logic [1:0]   RAA,
  input  logic         REA,
  input  logic [1:0]   RAB,
  input  logic         REB,
  input  logic [1:0]   C,
  input  logic         s2,
  output logic [W-1:0] out,
  output logic         carry,
  output logic         ovf,
  output logic         result_valid
);

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    WSEL_ALU  = 2'd0,
    WSEL_ZERO = 2'd1,
    WSEL_IN2  = 2'd2,
    WSEL_IN1  = 2'd3
  } wsel_t;

  logic [W-1:0] r_rf [4];
  logic [W-1:0] r_out;
  logic         r_carry;
  logic         r_valid;

  logic [W-1:0] w_a;
  logic [W-1:0] w_b;
  logic [W:0]   w_sum;
  logic [W:0]   w_diff;
  logic [W-1:0] w_alu;
  logic         w_carry;
  logic         w_ovf;
  logic [W-1:0] w_wdata;
  logic         w_flag_we;
  alu_op_t      w_op;
  wsel_t        w_wsel;

  assign w_op   = alu_op_t'(C);
  assign w_wsel = wsel_t'(s1);

  // Reads come straight from the flops, so a write this cycle is only
  // visible next cycle and the ALU->MUX1->RF path never loops.
  assign w_a = REA ? r_rf[RAA] : '0;
  assign w_b = REB ? r_rf[RAB] : '0;

  // Extra MSB of the difference is the borrow (A < B unsigned).
  assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
  assign w_diff = {1'b0, w_a} - {1'b0, w_b};

  always_comb begin
    w_alu   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    unique case (w_op)
      OP_ADD: begin
        w_alu   = w_sum[W-1:0];
        w_carry = w_sum[W];
        w_ovf   = (w_a[W-1] == w_b[W-1]) && (w_sum[W-1] != w_a[W-1]);
      end
      OP_SUB: begin
        w_alu   = w_diff[W-1:0];
        w_carry = w_diff[W];
        w_ovf   = (w_a[W-1] != w_b[W-1]) && (w_diff[W-1] != w_a[W-1]);
      end
      OP_AND: w_alu = w_a & w_b;
      OP_XOR: w_alu = w_a ^ w_b;
      default: ;
    endcase
  end

  always_comb begin
    w_wdata = '0;
    unique case (w_wsel)
      WSEL_ALU:  w_wdata = w_alu;
      WSEL_ZERO: w_wdata = '0;
      WSEL_IN2:  w_wdata = in2;
      WSEL_IN1:  w_wdata = in1;
      default: ;
    endcase
  end

  // Flags follow only the cycle whose ALU result is actually written back.
  assign w_flag_we = WE && (w_wsel == WSEL_ALU);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) r_rf[i] <= '0;
    end else if (WE) begin
      r_rf[WA] <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_carry <= 1'b0;
    end else if (w_flag_we) begin
      r_carry <= w_carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= s2;
      if (s2) r_out <= w_alu;
    end
  end

`ifdef CALC_SIGNED_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_flag_we) begin
      r_ovf <= w_ovf;
    end
  end

  assign ovf = r_ovf;
`else
  logic w_ovf_unused;
  assign w_ovf_unused = w_ovf;
  assign ovf          = 1'b0;
`endif

  assign out          = r_out;
  assign carry        = r_carry;
  assign result_valid = r_valid;

endmodule

// File: tb/tb_calc_datapath.sv
// Self-checking bench for calc_datapath (W=4): reset, ADD/SUB/AND/XOR full
// control sequences, reset in the op state, read-during-write and disabled
// read ports. Expected values are hand-computed constants.
module tb_calc_datapath;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] in1, in2;
  logic [1:0]   s1, WA, RAA, RAB, C;
  logic         WE, REA, REB, s2;
  logic [W-1:0] out;
  logic         carry, ovf, result_valid;

  int n_cmp = 0;
  int n_err = 0;

`ifdef CALC_SIGNED_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  calc_datapath #(.W(W)) dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2),
    .s1(s1), .WA(WA), .WE(WE), .RAA(RAA), .REA(REA), .RAB(RAB), .REB(REB),
    .C(C), .s2(s2),
    .out(out), .carry(carry), .ovf(ovf), .result_valid(result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl_idle();
    s1 = 2'd0; WA = 2'd0; WE = 1'b0;
    RAA = 2'd0; REA = 1'b0; RAB = 2'd0; REB = 1'b0;
    C = 2'd0; s2 = 1'b0;
  endtask

  // Full IDLE->WRITE1->WRITE2->READ->OP->OUTPUT sequence with checks.
  task automatic run_seq(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op, input logic [W-1:0] exp_out,
                         input logic exp_c, input logic exp_v,
                         input string name);
    // WRITE1: R1 <- in1 (in2 deliberately garbage, must not be sampled)
    ctl_idle(); s1 = 2'd3; WA = 2'd1; WE = 1'b1; in1 = a; in2 = ~b;
    step();
    n_cmp++;
    if (result_valid !== 1'b0) begin
      n_err++; $display("FAIL %s rv_w1: got %b want 0", name, result_valid);
    end
    // WRITE2: R2 <- in2
    ctl_idle(); s1 = 2'd2; WA = 2'd2; WE = 1'b1; in2 = b; in1 = ~a;
    step();
    // READ
    ctl_idle(); REA = 1'b1; RAA = 2'd1; REB = 1'b1; RAB = 2'd2;
    in1 = '0; in2 = '0;
    step();
    n_cmp++;
    if (result_valid !== 1'b0) begin
      n_err++; $display("FAIL %s rv_rd: got %b want 0", name, result_valid);
    end
    // OP: R3 <- R1 op R2, flags captured
    s1 = 2'd0; WA = 2'd3; WE = 1'b1; C = op;
    step();
    n_cmp++;
    if (carry !== exp_c) begin
      n_err++; $display("FAIL %s carry: got %b want %b", name, carry, exp_c);
    end
    n_cmp++;
    if (ovf !== (exp_v & OVF_ON)) begin
      n_err++; $display("FAIL %s ovf: got %b want %b", name, ovf, exp_v & OVF_ON);
    end
    n_cmp++;
    if (result_valid !== 1'b0) begin
      n_err++; $display("FAIL %s rv_op: got %b want 0", name, result_valid);
    end
    // OUTPUT: out <- R3 & R3
    ctl_idle(); REA = 1'b1; RAA = 2'd3; REB = 1'b1; RAB = 2'd3;
    C = 2'd2; s2 = 1'b1;
    step();
    n_cmp++;
    if (result_valid !== 1'b1) begin
      n_err++; $display("FAIL %s rv_out: got %b want 1", name, result_valid);
    end
    n_cmp++;
    if (out !== exp_out) begin
      n_err++; $display("FAIL %s out: got %h want %h", name, out, exp_out);
    end
    // back to IDLE: pulse ends, out and flags hold
    ctl_idle();
    step();
    n_cmp++;
    if (result_valid !== 1'b0 || out !== exp_out || carry !== exp_c) begin
      n_err++;
      $display("FAIL %s hold: rv=%b out=%h c=%b want rv=0 out=%h c=%b",
               name, result_valid, out, carry, exp_out, exp_c);
    end
  endtask

  task automatic test_reset();
    ctl_idle(); in1 = '0; in2 = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_cmp++;
    if (out !== '0 || carry !== 1'b0 || ovf !== 1'b0 || result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outs: out=%h c=%b v=%b rv=%b want 0/0/0/0",
               out, carry, ovf, result_valid);
    end
    for (int i = 0; i < 4; i++) begin
      ctl_idle(); REA = 1'b1; RAA = 2'(i); REB = 1'b1; RAB = 2'(i);
      C = 2'd3; s2 = 1'b1;
      // XOR of equal values is 0 regardless; use ADD to expose R[i]*2
      C = 2'd0;
      step();
      n_cmp++;
      if (out !== '0 || result_valid !== 1'b1) begin
        n_err++;
        $display("FAIL reset_read R%0d: out=%h rv=%b want 0/1", i, out, result_valid);
      end
    end
    ctl_idle();
    step();
  endtask

  task automatic test_add();
    run_seq(4'd5, 4'd3, 2'd0, 4'd8, 1'b0, 1'b1, "add_5_3");
    run_seq(4'd9, 4'd8, 2'd0, 4'd1, 1'b1, 1'b1, "add_9_8");
  endtask

  task automatic test_sub();
    run_seq(4'd3, 4'd5, 2'd1, 4'hE, 1'b1, 1'b0, "sub_3_5");
  endtask

  task automatic test_logic();
    run_seq(4'hC, 4'hA, 2'd2, 4'h8, 1'b0, 1'b0, "and_c_a");
    run_seq(4'hC, 4'hA, 2'd3, 4'h6, 1'b0, 1'b0, "xor_c_a");
  endtask

  task automatic test_reset_midop();
    // out currently 6 from XOR, R3 = 6
    ctl_idle(); s1 = 2'd3; WA = 2'd1; WE = 1'b1; in1 = 4'd5;
    step();
    ctl_idle(); s1 = 2'd2; WA = 2'd2; WE = 1'b1; in2 = 4'd3;
    step();
    ctl_idle(); REA = 1'b1; RAA = 2'd1; REB = 1'b1; RAB = 2'd2;
    step();
    s1 = 2'd0; WA = 2'd3; WE = 1'b1; C = 2'd0; rst = 1'b1;
    step();
    rst = 1'b0;
    ctl_idle();
    n_cmp++;
    if (out !== '0 || carry !== 1'b0 || ovf !== 1'b0 || result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midop_rst: out=%h c=%b v=%b rv=%b want 0/0/0/0",
               out, carry, ovf, result_valid);
    end
    step();
    n_cmp++;
    if (result_valid !== 1'b0) begin
      n_err++; $display("FAIL midop_rv: got %b want 0", result_valid);
    end
    // R3 and R1 must both be cleared: out <- R3 + R1
    REA = 1'b1; RAA = 2'd3; REB = 1'b1; RAB = 2'd1; C = 2'd0; s2 = 1'b1;
    step();
    n_cmp++;
    if (out !== '0 || result_valid !== 1'b1) begin
      n_err++; $display("FAIL midop_r3: out=%h rv=%b want 0/1", out, result_valid);
    end
    ctl_idle();
    step();
    run_seq(4'd5, 4'd3, 2'd0, 4'd8, 1'b0, 1'b1, "rerun_add");
  endtask

  task automatic test_read_during_write();
    // R1 = 5 from the rerun; write 7 while reading R1 through A (+0 on B)
    ctl_idle(); s1 = 2'd3; WA = 2'd1; WE = 1'b1; in1 = 4'd7;
    REA = 1'b1; RAA = 2'd1; REB = 1'b0; C = 2'd0; s2 = 1'b1;
    step();
    n_cmp++;
    if (out !== 4'd5) begin
      n_err++; $display("FAIL rdw_old: got %h want 5", out);
    end
    WE = 1'b0;
    step();
    n_cmp++;
    if (out !== 4'd7) begin
      n_err++; $display("FAIL rdw_new: got %h want 7", out);
    end
    // both ports disabled, R1 = 7 nonzero: must read 0
    REA = 1'b0; REB = 1'b0; RAB = 2'd1;
    step();
    n_cmp++;
    if (out !== 4'd0) begin
      n_err++; $display("FAIL rd_disabled: got %h want 0", out);
    end
    // only B enabled: 0 xor R1 = 7
    REB = 1'b1; C = 2'd3;
    step();
    n_cmp++;
    if (out !== 4'd7) begin
      n_err++; $display("FAIL rd_a_off: got %h want 7", out);
    end
    ctl_idle();
    step();
  endtask

  initial begin
    rst = 1'b1;
    ctl_idle(); in1 = '0; in2 = '0;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_reset_midop();
    test_read_during_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

endmodule
